key_debounce_array: RTL
=======================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 The block SHALL provide parameter KEY_NUM, default 4, number of independent key channels (1..16).
REQ-002 The block SHALL provide parameter CNT_MAX, default 20'd999_999, debounce period minus one in sys_clk cycles (20 ms at 50 MHz).
REQ-003 The block SHALL provide parameter LONG_TICKS, default 8'd50, long-press threshold in debounce periods (1 s).
REQ-004 The block SHALL provide parameter REPEAT_TICKS, default 8'd10, auto-repeat interval in debounce periods (200 ms).
REQ-005 sys_clk  input  1  system clock, 50 MHz.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  KEY_NUM  raw key pins, active-low (0 = pressed), asynchronous to sys_clk.
REQ-008 repeat_en  input  KEY_NUM  per-channel auto-repeat enable, synchronous, level.
REQ-009 key_level  output  KEY_NUM  debounced state, 1 = pressed.
REQ-010 key_press  output  KEY_NUM  one-cycle pulse on debounced press.
REQ-011 key_release  output  KEY_NUM  one-cycle pulse on debounced release.
REQ-012 key_long  output  KEY_NUM  one-cycle pulse when hold reaches LONG_TICKS.
REQ-013 key_repeat  output  KEY_NUM  one-cycle pulse every REPEAT_TICKS after key_long while held and repeat_en set.

Function
REQ-014 Each key_in bit SHALL pass a 2-FF synchroniser before any use; sync FFs reset to 1 (released).
REQ-015 Per channel, debounce counter (20 bit) SHALL clear when synced raw equals debounced state, else increment.
REQ-016 When counter equals CNT_MAX and raw still differs, next edge SHALL flip key_level, clear counter, and pulse key_press (to pressed) or key_release (to released).
REQ-017 Latency: key_in held stable at new value -> edge flag pulse high after exactly CNT_MAX+3 sys_clk edges; any bounce restarts the count.
REQ-018 A shared free-running prescaler SHALL emit one-cycle tick every CNT_MAX+1 cycles; hold timing uses ticks (jitter up to one tick accepted).
REQ-019 Per channel hold counter (8 bit) SHALL clear on key_press and while key_level=0, increment on tick while key_level=1, saturate at LONG_TICKS.
REQ-020 key_long SHALL pulse once on the tick where hold counter reaches LONG_TICKS; never again until release and re-press.
REQ-021 After key_long, repeat counter SHALL count ticks; at REPEAT_TICKS it pulses key_repeat (if repeat_en=1) and wraps to 0.
REQ-022 repeat_en deasserted mid-hold SHALL suppress key_repeat pulses; counter keeps running; re-assert resumes without re-press.
REQ-023 Tick coinciding with release edge: release SHALL win; no key_long/key_repeat pulse that cycle.
REQ-024 key_press and key_release SHALL never assert in the same cycle on one channel; channels fully independent, simultaneous events on different channels allowed.

Reset
REQ-025 On sys_rst_n low all outputs SHALL be 0, all counters 0, key_level 0, prescaler 0, immediately (asynchronous).
REQ-026 Reset asserted mid-press SHALL produce no key_release; after deassert a still-held key SHALL produce key_press after CNT_MAX+3 edges.

Structure
REQ-027 A shared package key_pkg SHALL hold KEY_NUM_MAX, default debounce/tick constants, and counter width constants.
REQ-028 Per-channel logic SHALL be one sub-module key_debounce_ch, instantiated KEY_NUM times by generate; prescaler lives in top.
REQ-029 All outputs SHALL be registered; no combinational path from key_in or repeat_en to outputs.

Verification (CNT_MAX=9, LONG_TICKS=5, REPEAT_TICKS=2)
REQ-030 key_in[0] 1->0 held -> key_press[0] one pulse after 12 edges, key_level[0]=1 thereafter.
REQ-031 key_in[1] toggles every 5 cycles for 100 cycles -> no pulses on channel 1, key_level[1]=0.
REQ-032 Hold key 0 for 80 cycles, repeat_en=0 -> one key_long 40-50 cycles after press; no key_repeat; key_release 12 edges after key_in returns to 1.
REQ-033 Hold key 2 for 150 cycles, repeat_en[2]=1 -> key_long then key_repeat every 20 cycles until release.
REQ-034 Press keys 0 and 3 same cycle -> both key_press in same cycle; reset mid-hold -> all outputs 0, no key_release, key_press re-issued 12 edges after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the key debounce array: channel limits,
// default timing for a 50 MHz clock, and counter widths.
package key_pkg;

  localparam int KEY_NUM_MAX = 16;
  localparam int DB_CNT_W    = 20;
  localparam int HOLD_CNT_W  = 8;

  localparam logic [DB_CNT_W-1:0]   CNT_MAX_DEF      = 20'd999_999;
  localparam logic [HOLD_CNT_W-1:0] LONG_TICKS_DEF   = 8'd50;
  localparam logic [HOLD_CNT_W-1:0] REPEAT_TICKS_DEF = 8'd10;

  typedef enum logic [1:0] {
    HOLD_IDLE,
    HOLD_COUNT,
    HOLD_REPEAT
  } hold_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, counter-based debouncer with press/release
// pulses, and a tick-driven hold tracker producing long-press and auto-repeat pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0]   CNT_MAX      = CNT_MAX_DEF,
  parameter logic [HOLD_CNT_W-1:0] LONG_TICKS   = LONG_TICKS_DEF,
  parameter logic [HOLD_CNT_W-1:0] REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in_i,
  input  logic repeat_en_i,
  input  logic tick_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_long_o,
  output logic key_repeat_o
);

  logic                  sync1_q, sync2_q;
  logic                  raw_pressed;
  logic                  differs;
  logic                  flip;
  logic [DB_CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic                  level_q, press_q, release_q;
  hold_state_e           state_q;
  logic [HOLD_CNT_W-1:0] hold_q, rep_q;
  logic                  long_q, repeat_q;

  // Sync FFs idle at 1 so reset looks like a released key.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw_pressed = ~sync2_q;
  assign differs     = raw_pressed != level_q;
  assign flip        = differs && (db_cnt_q == CNT_MAX);

  always_comb begin
    db_cnt_d = db_cnt_q + DB_CNT_W'(1);
    if (!differs || flip) db_cnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_q ^ flip;
      press_q   <= flip & raw_pressed;
      release_q <= flip & ~raw_pressed;
    end
  end

  // A debounced edge restarts hold tracking and outranks any tick in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= HOLD_IDLE;
      hold_q   <= '0;
      rep_q    <= '0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      if (flip) begin
        state_q <= raw_pressed ? HOLD_COUNT : HOLD_IDLE;
        hold_q  <= '0;
        rep_q   <= '0;
      end else begin
        case (state_q)
          HOLD_IDLE: begin
            hold_q <= '0;
            rep_q  <= '0;
          end
          HOLD_COUNT: begin
            if (tick_i && (hold_q != LONG_TICKS)) begin
              hold_q <= hold_q + HOLD_CNT_W'(1);
              if (hold_q + HOLD_CNT_W'(1) == LONG_TICKS) begin
                long_q  <= 1'b1;
                rep_q   <= '0;
                state_q <= HOLD_REPEAT;
              end
            end
          end
          HOLD_REPEAT: begin
            if (tick_i) begin
              if (rep_q + HOLD_CNT_W'(1) >= REPEAT_TICKS) begin
                rep_q    <= '0;
                repeat_q <= repeat_en_i;
              end else begin
                rep_q <= rep_q + HOLD_CNT_W'(1);
              end
            end
          end
          default: state_q <= HOLD_IDLE;
        endcase
      end
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_long_o    = long_q;
  assign key_repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced keys sharing one free-running prescaler that
// provides the hold-timing tick once per debounce period.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int                    KEY_NUM      = 4,
  parameter logic [DB_CNT_W-1:0]   CNT_MAX      = CNT_MAX_DEF,
  parameter logic [HOLD_CNT_W-1:0] LONG_TICKS   = LONG_TICKS_DEF,
  parameter logic [HOLD_CNT_W-1:0] REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic [KEY_NUM-1:0] repeat_en,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  logic [DB_CNT_W-1:0] presc_q, presc_d;
  logic                tick_q;

  always_comb begin
    presc_d = presc_q + DB_CNT_W'(1);
    if (presc_q == CNT_MAX) presc_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= (presc_q == CNT_MAX);
    end
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX      (CNT_MAX),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .key_in_i      (key_in[i]),
      .repeat_en_i   (repeat_en[i]),
      .tick_i        (tick_q),
      .key_level_o   (key_level[i]),
      .key_press_o   (key_press[i]),
      .key_release_o (key_release[i]),
      .key_long_o    (key_long[i]),
      .key_repeat_o  (key_repeat[i])
    );
  end

endmodule
